// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: diff_out = a_in - b_in - bin (mod 2^WIDTH),
//   borrow_out = final borrow. One bit is processed per clock, LSB first,
//   through a single fullsub cell. An operation takes WIDTH RUN cycles plus
//   one DONE cycle.
//
//   Ports
//     clk        : system clock, rising edge
//     rst        : synchronous active-high reset
//     start      : begin a subtraction (sampled only while idle)
//     a_in       : minuend, captured on an accepted start
//     b_in       : subtrahend, captured on an accepted start
//     bin        : initial borrow-in, captured on an accepted start
//     busy       : high while an operation is running or completing
//     done       : one-cycle pulse when diff_out/borrow_out are updated
//     diff_out   : registered difference, held until the next completion
//     borrow_out : registered final borrow, held until the next completion
// ---------------------------------------------------------------------------

// Single-bit full subtractor: diff = a - b - cin, borrow when the result
// goes negative.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ cin;
  assign borrow = (~a & b) | (~(a ^ b) & cin);

endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fs_diff;
  logic             fs_borrow;

  fullsub u_fullsub (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .cin    (brw_q),
    .diff   (fs_diff),
    .borrow (fs_borrow)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {fs_diff, res_q[WIDTH-1:1]};
        brw_d = fs_borrow;
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit: publish the result directly from the cell output so the
        // outputs update on the same edge as the final shift.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = {fs_diff, res_q[WIDTH-1:1]};
          bout_d  = fs_borrow;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign diff_out   = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). Expected results
//   come from plain integer arithmetic on the captured operands.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff_out;
  logic         borrow_out;

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {borrow, diff} from signed integer arithmetic.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int          d;
    logic [31:0] du;
    d  = int'(a) - int'(b) - int'(c);
    du = d;
    return {(d < 0), du[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; scrambles inputs during RUN, checks latency, busy
  // duration, result and return to idle.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    logic [W:0] exp;
    int         n;
    int         busy_cnt;
    bit         seen;
    exp   = ref_sub(a, b, c);
    a_in  = a;
    b_in  = b;
    bin   = c;
    start = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    n        = 0;
    seen     = 1'b0;
    while (n < 20 && !seen) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      bin  = 1'($urandom);
      tick();
      n++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, n, W);
    check({tag, "_diff"}, 32'(diff_out), 32'(exp[W-1:0]));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(exp[W]));
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_busy_cycles"}, busy_cnt, W + 1);
  endtask

  initial begin
    logic [W:0] e1, e2;
    int         n;
    int         d_cnt;
    int         d_at[2];

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    bin   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff_out), 32'd0);
    check("reset_borrow", 32'(borrow_out), 32'd0);
    tick();
    check("idle_hold_busy", 32'(busy), 32'd0);

    // Directed cases
    do_op("basic", 8'h05, 8'h03, 1'b0);
    check("basic_value", 32'(diff_out), 32'h02);
    do_op("under1", 8'h00, 8'h01, 1'b0);
    check("under1_value", 32'({borrow_out, diff_out}), 32'h1FF);
    do_op("under2", 8'h00, 8'h00, 1'b1);
    check("under2_value", 32'({borrow_out, diff_out}), 32'h1FF);
    do_op("ones", 8'hFF, 8'hFF, 1'b1);
    check("ones_value", 32'({borrow_out, diff_out}), 32'h1FF);
    do_op("a5_5a", 8'hA5, 8'h5A, 1'b0);
    check("a5_5a_value", 32'({borrow_out, diff_out}), 32'h04B);

    // Start pulsed during RUN must be ignored and not queued.
    a_in  = 8'h33;
    b_in  = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    d_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) d_cnt++;
    end
    check("ignored_start_dones", d_cnt, 1);
    check("ignored_start_diff", 32'(diff_out), 32'h22);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Start held high across two operations.
    e1    = ref_sub(8'h10, 8'h01, 1'b0);
    e2    = ref_sub(8'h03, 8'h07, 1'b0);
    a_in  = 8'h10;
    b_in  = 8'h01;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    a_in  = 8'h03;
    b_in  = 8'h07;
    d_cnt = 0;
    d_at  = '{0, 0};
    n     = 0;
    while (n < 40 && d_cnt < 2) begin
      tick();
      n++;
      if (done) begin
        d_at[d_cnt] = n;
        if (d_cnt == 0) begin
          check("b2b_first", 32'({borrow_out, diff_out}), 32'(e1));
        end else begin
          check("b2b_second", 32'({borrow_out, diff_out}), 32'(e2));
          start = 1'b0;
        end
        d_cnt++;
      end
    end
    start = 1'b0;
    check("b2b_count", d_cnt, 2);
    check("b2b_spacing", d_at[1] - d_at[0], W + 2);
    check("b2b_first_latency", d_at[0], W);
    tick();
    tick();
    check("b2b_idle", 32'(busy), 32'd0);

    // Reset during the third RUN cycle aborts without a done pulse.
    a_in  = 8'h77;
    b_in  = 8'h12;
    bin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff_out), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    d_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) d_cnt++;
    end
    check("abort_no_done", d_cnt, 0);
    do_op("after_abort", 8'h09, 8'h04, 1'b0);
    check("after_abort_value", 32'({borrow_out, diff_out}), 32'h005);

    // Random operands against the reference model.
    for (int i = 0; i < 300; i++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
